cnt_sequencer: RTL and testbench
================================

CNT_SEQUENCER -- requirements
Module: cnt_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_valid  input  1  command valid.
REQ-005 o_ready  output  1  command ready; a command is accepted on an edge where i_valid && o_ready.
REQ-006 i_dir  input  1  command direction: 0 counts up (+1), 1 counts down (-1).
REQ-007 i_target  input  WIDTH  command target count value.
REQ-008 i_pause  input  1  pause request; level-sensitive.
REQ-009 i_abort  input  1  abort request; level-sensitive.
REQ-010 o_cnt  output  WIDTH  current counter value; registered.
REQ-011 o_busy  output  1  high in RUN or PAUSE.
REQ-012 o_done  output  1  one-cycle pulse on normal completion.
REQ-013 o_aborted  output  1  one-cycle pulse on abort.
REQ-014 o_steps  output  WIDTH  steps taken by the current or last command; registered.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE, registered and encoded in 2 bits.
REQ-016 o_ready SHALL be 1 only in IDLE, decoded from state (not registered).
REQ-017 On accept in IDLE, the block SHALL latch i_dir and i_target and clear o_steps to 0; o_cnt SHALL be held, so a command continues from the current value.
REQ-018 On accept with i_target == o_cnt, the block SHALL go directly to DONE: zero steps, o_cnt unchanged.
REQ-019 On accept otherwise, the block SHALL go to RUN; the first step SHALL occur on the next edge.
REQ-020 In RUN with i_pause=0 and i_abort=0, each edge SHALL set o_cnt to o_cnt±1 modulo 2^WIDTH and increment o_steps by 1.
REQ-021 Wrap-around is legal: up 15->0, down 0->15 for WIDTH=4.
REQ-022 In RUN, the edge whose step makes o_cnt equal the latched target SHALL move the FSM to DONE, so o_done is high in the first cycle o_cnt == target.
REQ-023 Latency SHALL be exactly N+1 edges from accept to DONE, where N = (target-start) mod 2^WIDTH when counting up and (start-target) mod 2^WIDTH when counting down.
REQ-024 In RUN with i_pause=1, the block SHALL not step and SHALL go to PAUSE.
REQ-025 In PAUSE, o_cnt and o_steps SHALL hold; when i_pause=0 the block SHALL return to RUN without stepping on that edge, and stepping resumes on the following edge.
REQ-026 i_abort=1 in RUN or PAUSE SHALL move the FSM to IDLE on the next edge, hold o_cnt and o_steps, and assert o_aborted for one cycle; o_done SHALL not assert.
REQ-027 Priority in RUN SHALL be abort > pause > step/complete; an abort on the edge that would complete the command suppresses the final step.
REQ-028 i_abort and i_pause in IDLE or DONE SHALL be ignored.
REQ-029 DONE SHALL last exactly one cycle and then go to IDLE; o_done = (state==DONE); o_ready=0 in DONE.
REQ-030 i_valid in any state other than IDLE SHALL be ignored; commands are not queued.
REQ-031 o_aborted SHALL be a registered one-cycle pulse, high in the first IDLE cycle after an abort.

Reset
REQ-032 While i_rst=1, regardless of clock: state=IDLE, o_cnt=0, o_steps=0, o_done=0, o_aborted=0, o_busy=0, o_ready=1, and the latched dir/target = 0.
REQ-033 Reset asserted mid-command SHALL discard the command with no o_done or o_aborted pulse.
REQ-034 The first command after reset deassertion SHALL be acceptable on the first clock edge.

Verification
REQ-035 Up count: from o_cnt=3, command dir=0, target=6 -> o_cnt 4,5,6 on the next 3 edges; o_done high in the cycle o_cnt=6; o_steps=3; o_ready back to 1 one cycle later.
REQ-036 Down wrap: from o_cnt=1, command dir=1, target=14 -> o_cnt 0,15,14; o_done with o_steps=3.
REQ-037 Zero-step: o_cnt=5, command target=5 -> DONE on the next cycle, o_cnt=5, o_steps=0, no RUN cycle.
REQ-038 Pause: up 0->4 with i_pause=1 for 3 cycles after o_cnt=2 -> o_cnt holds 2 through PAUSE, one resume cycle without a step, then 3,4; o_done with o_steps=4.
REQ-039 Abort vs completion: up 0->2, i_abort=1 on the edge where o_cnt would reach 2 -> o_cnt stays 1, o_aborted pulses once, no o_done, o_steps=1.
REQ-040 Async reset mid-RUN: i_rst pulsed between edges at o_cnt=7 -> outputs return immediately to reset values; o_done and o_aborted never assert.

Source files
------------

// File: rtl/cnt_sequencer.sv
// cnt_sequencer
//
// Command-driven up/down counter. A command (direction + target) is
// accepted from IDLE with a valid/ready handshake. The counter then steps
// by one per clock until it reaches the target, wrapping modulo 2^WIDTH.
// The counter continues from whatever value it already holds. A command
// can be paused or aborted while it is running.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_valid    command valid
//   o_ready    command ready (high only in IDLE)
//   i_dir      command direction: 0 = up, 1 = down
//   i_target   command target count value
//   i_pause    pause request (level)
//   i_abort    abort request (level)
//   o_cnt      current counter value
//   o_busy     high while a command is running or paused
//   o_done     one-cycle pulse on normal completion
//   o_aborted  one-cycle pulse, first IDLE cycle after an abort
//   o_steps    steps taken by the current or last command

module cnt_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [WIDTH-1:0] o_steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] steps_q;
    logic             aborted_q;
    logic [WIDTH-1:0] cnt_next;

    // Value the counter takes if a step happens this cycle. Plain
    // add/subtract gives the wrap-around for free.
    always_comb begin
        cnt_next = cnt_q;
        if (dir_q) begin
            cnt_next = cnt_q - ONE;
        end else begin
            cnt_next = cnt_q + ONE;
        end
    end

    // Main sequencer. Abort is checked before pause, and pause before the
    // step, so an abort on the would-be final edge leaves the counter one
    // short of the target. The aborted flag defaults low every cycle so it
    // is only a single-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            target_q  <= '0;
            cnt_q     <= '0;
            steps_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        dir_q    <= i_dir;
                        target_q <= i_target;
                        steps_q  <= '0;
                        if (i_target == cnt_q) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (i_pause) begin
                        state <= PAUSE;
                    end else begin
                        cnt_q   <= cnt_next;
                        steps_q <= steps_q + ONE;
                        if (cnt_next == target_q) begin
                            state <= DONE;
                        end
                    end
                end
                PAUSE: begin
                    // Leaving PAUSE costs one edge with no step.
                    if (i_abort) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (!i_pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decode directly from the state register.
    always_comb begin
        o_ready   = (state == IDLE);
        o_busy    = (state == RUN) || (state == PAUSE);
        o_done    = (state == DONE);
        o_cnt     = cnt_q;
        o_steps   = steps_q;
        o_aborted = aborted_q;
    end

endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer
//
// Directed bench for cnt_sequencer (WIDTH = 4). Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the active rising edge. Each task below covers one scenario. The counter
// value left by one scenario is the starting value for the next.

module tb_cnt_sequencer;

    localparam int W = 4;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_dir;
    logic [W-1:0] i_target;
    logic         i_pause;
    logic         i_abort;
    logic [W-1:0] o_cnt;
    logic         o_busy;
    logic         o_done;
    logic         o_aborted;
    logic [W-1:0] o_steps;

    int checks;
    int failures;

    cnt_sequencer #(.WIDTH(W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_dir     (i_dir),
        .i_target  (i_target),
        .i_pause   (i_pause),
        .i_abort   (i_abort),
        .o_cnt     (o_cnt),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_aborted (o_aborted),
        .o_steps   (o_steps)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Presents a command for exactly one rising edge. The task returns on
    // the falling edge just after the accept edge.
    task automatic issue(input logic dir, input logic [W-1:0] target);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_dir    = dir;
        i_target = target;
        @(negedge i_clk);
        i_valid  = 1'b0;
    endtask

    // Moves the counter to a known value for the next scenario. The wait
    // for completion is bounded, and the final counter value is checked.
    task automatic do_cmd(input logic dir, input logic [W-1:0] target);
        int n;
        issue(dir, target);
        n = 0;
        while (!o_done && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL setup_timeout: o_done=%b after %0d cycles, required 1", o_done, n);
        end
        checks++;
        if (o_cnt !== target) begin
            failures++;
            $display("[TB] FAIL setup_cnt: o_cnt=%0d, required %0d", o_cnt, target);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_valid = 1'b0; i_dir = 1'b0; i_target = '0; i_pause = 1'b0; i_abort = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_ready, o_busy, o_done, o_aborted} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_flags: ready/busy/done/aborted=%b, required 1000",
                     {o_ready, o_busy, o_done, o_aborted});
        end
        checks++;
        if (o_cnt !== 4'd0 || o_steps !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_values: cnt=%0d steps=%0d, required 0 0", o_cnt, o_steps);
        end
        i_rst = 1'b0;
    endtask

    // Counts up from 3 to 6: 4,5,6, then completion, then ready again.
    task automatic test_up_count;
        issue(1'b0, 4'd6);
        checks++;
        if (o_cnt !== 4'd3 || o_busy !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL up_accept: cnt=%0d busy=%b ready=%b, required 3 1 0", o_cnt, o_busy, o_ready);
        end
        for (int k = 4; k <= 6; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_cnt !== k[W-1:0] || o_done !== (k == 6)) begin
                failures++;
                $display("[TB] FAIL up_step: cnt=%0d done=%b, required %0d %b", o_cnt, o_done, k, (k == 6));
            end
        end
        checks++;
        if (o_steps !== 4'd3) begin
            failures++;
            $display("[TB] FAIL up_steps: steps=%0d, required 3", o_steps);
        end
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL up_ready: ready=%b done=%b, required 1 0", o_ready, o_done);
        end
    endtask

    // Counts down from 1 to 14 through the wrap: 0,15,14.
    task automatic test_down_wrap;
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 4'd0; exp_seq[1] = 4'd15; exp_seq[2] = 4'd14;
        issue(1'b1, 4'd14);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_cnt !== exp_seq[k] || o_done !== (k == 2)) begin
                failures++;
                $display("[TB] FAIL down_step: cnt=%0d done=%b, required %0d %b", o_cnt, o_done, exp_seq[k], (k == 2));
            end
        end
        checks++;
        if (o_steps !== 4'd3) begin
            failures++;
            $display("[TB] FAIL down_steps: steps=%0d, required 3", o_steps);
        end
        @(negedge i_clk);
    endtask

    // A target equal to the current count goes straight to DONE.
    task automatic test_zero_step;
        issue(1'b0, 4'd5);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_done: done=%b busy=%b ready=%b, required 1 0 0", o_done, o_busy, o_ready);
        end
        checks++;
        if (o_cnt !== 4'd5 || o_steps !== 4'd0) begin
            failures++;
            $display("[TB] FAIL zero_values: cnt=%0d steps=%0d, required 5 0", o_cnt, o_steps);
        end
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_idle: ready=%b done=%b, required 1 0", o_ready, o_done);
        end
    endtask

    // Counts up from 0 to 4 with a 3-cycle pause at 2. A stray command is
    // presented during the pause and must be ignored.
    task automatic test_pause;
        logic [W-1:0] exp_seq [6];
        exp_seq[0] = 4'd2; exp_seq[1] = 4'd2; exp_seq[2] = 4'd2;
        exp_seq[3] = 4'd2; exp_seq[4] = 4'd3; exp_seq[5] = 4'd4;
        issue(1'b0, 4'd4);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_cnt !== 4'd2) begin
            failures++;
            $display("[TB] FAIL pause_pre: cnt=%0d, required 2", o_cnt);
        end
        i_pause = 1'b1;
        i_valid = 1'b1;
        i_target = 4'd9;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (k == 2) begin
                i_pause = 1'b0;
                i_valid = 1'b0;
            end
            checks++;
            if (o_cnt !== exp_seq[k] || o_busy !== (k < 5) || o_done !== (k == 5)) begin
                failures++;
                $display("[TB] FAIL pause_seq%0d: cnt=%0d busy=%b done=%b, required %0d %b %b",
                         k, o_cnt, o_busy, o_done, exp_seq[k], (k < 5), (k == 5));
            end
        end
        checks++;
        if (o_steps !== 4'd4) begin
            failures++;
            $display("[TB] FAIL pause_steps: steps=%0d, required 4", o_steps);
        end
        @(negedge i_clk);
    endtask

    // An abort on the edge that would complete 0->2 leaves the count at 1.
    task automatic test_abort;
        issue(1'b0, 4'd2);
        @(negedge i_clk);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        checks++;
        if (o_cnt !== 4'd1 || o_steps !== 4'd1) begin
            failures++;
            $display("[TB] FAIL abort_values: cnt=%0d steps=%0d, required 1 1", o_cnt, o_steps);
        end
        checks++;
        if (o_aborted !== 1'b1 || o_done !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_pulse: aborted=%b done=%b ready=%b, required 1 0 1", o_aborted, o_done, o_ready);
        end
        @(negedge i_clk);
        checks++;
        if (o_aborted !== 1'b0 || o_done !== 1'b0 || o_cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL abort_after: aborted=%b done=%b cnt=%0d, required 0 0 1", o_aborted, o_done, o_cnt);
        end
    endtask

    // Pause and abort must have no effect in IDLE.
    task automatic test_idle_ignore;
        i_pause = 1'b1;
        i_abort = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_aborted !== 1'b0 || o_cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL idle_ignore: ready=%b busy=%b aborted=%b cnt=%0d, required 1 0 0 1",
                     o_ready, o_busy, o_aborted, o_cnt);
        end
        i_pause = 1'b0;
        i_abort = 1'b0;
    endtask

    // Holds valid from the DONE cycle onward. It is ignored in DONE and then
    // accepted on the first IDLE edge. The command is 3 down to 2.
    task automatic test_back_to_back;
        int n;
        issue(1'b0, 4'd3);
        n = 0;
        while (!o_done && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_done !== 1'b1 || o_cnt !== 4'd3) begin
            failures++;
            $display("[TB] FAIL b2b_first: done=%b cnt=%0d, required 1 3", o_done, o_cnt);
        end
        i_valid = 1'b1; i_dir = 1'b1; i_target = 4'd2;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_cnt !== 4'd3) begin
            failures++;
            $display("[TB] FAIL b2b_done_ignore: ready=%b busy=%b cnt=%0d, required 1 0 3", o_ready, o_busy, o_cnt);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_steps !== 4'd0) begin
            failures++;
            $display("[TB] FAIL b2b_accept: busy=%b steps=%0d, required 1 0", o_busy, o_steps);
        end
        @(negedge i_clk);
        checks++;
        if (o_cnt !== 4'd2 || o_done !== 1'b1 || o_steps !== 4'd1) begin
            failures++;
            $display("[TB] FAIL b2b_second: cnt=%0d done=%b steps=%0d, required 2 1 1", o_cnt, o_done, o_steps);
        end
        @(negedge i_clk);
    endtask

    // Asserts reset between edges while running 2->10 at count 7. A command
    // is then presented so that it arrives on the first edge after release.
    task automatic test_async_reset;
        int n;
        logic saw_pulse;
        issue(1'b0, 4'd10);
        n = 0;
        while (o_cnt !== 4'd7 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_cnt !== 4'd7 || o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_reach: cnt=%0d busy=%b, required 7 1", o_cnt, o_busy);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_cnt !== 4'd0 || o_steps !== 4'd0 || {o_ready, o_busy, o_done, o_aborted} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL areset_immediate: cnt=%0d steps=%0d ready/busy/done/aborted=%b, required 0 0 1000",
                     o_cnt, o_steps, {o_ready, o_busy, o_done, o_aborted});
        end
        saw_pulse = 1'b0;
        @(negedge i_clk);
        saw_pulse = saw_pulse | o_done | o_aborted;
        i_rst = 1'b0;
        i_valid = 1'b1; i_dir = 1'b0; i_target = 4'd2;
        @(negedge i_clk);
        i_valid = 1'b0;
        saw_pulse = saw_pulse | o_done | o_aborted;
        checks++;
        if (o_busy !== 1'b1 || o_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL areset_first_cmd: busy=%b cnt=%0d, required 1 0", o_busy, o_cnt);
        end
        @(negedge i_clk);
        saw_pulse = saw_pulse | o_aborted;
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_cnt !== 4'd2) begin
            failures++;
            $display("[TB] FAIL areset_cmd_done: done=%b cnt=%0d, required 1 2", o_done, o_cnt);
        end
        checks++;
        if (saw_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL areset_no_pulse: saw done/aborted=%b, required 0", saw_pulse);
        end
        @(negedge i_clk);
    endtask

    // Scenario sequence. The do_cmd calls set up the starting count for
    // the scenario that follows them.
    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        do_cmd(1'b0, 4'd3);
        test_up_count;
        do_cmd(1'b1, 4'd1);
        test_down_wrap;
        do_cmd(1'b0, 4'd5);
        test_zero_step;
        do_cmd(1'b0, 4'd0);
        test_pause;
        do_cmd(1'b0, 4'd0);
        test_abort;
        test_idle_ignore;
        test_back_to_back;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
